// File: rtl/jstk_spi_reader_pkg.sv
// Shared definitions for the Pmod JSTK reader: FSM state encoding, transaction
// framing constants and the TX byte builder.
package jstk_spi_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StGap,
    StDone
  } state_e;

  localparam int unsigned NumBytes     = 5;
  localparam logic [5:0]  LedCmdPrefix = 6'b100000;
  localparam logic [9:0]  ResetCentre  = 10'd512;

  // Byte 0 carries the LED command; the remaining bytes are don't-care fill.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [1:0] led);
    return (idx == 3'd0) ? {LedCmdPrefix, led} : 8'h00;
  endfunction

endpackage

// File: rtl/jstk_spi_reader_spi_byte_shifter.sv
// 8-bit SPI mode-0 shifter. A start pulse (while idle) loads tx and runs eight
// SCLK periods of 2*SCLK_DIV clk cycles, low half first. mosi is MSB first and
// changes only while sclk is low; miso is sampled on the clk edge at which sclk
// rises. done is high during the final clk cycle of the byte, when rx is complete.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a byte (ignored while busy)
//   tx         byte to transmit
//   miso       serial input
//   sclk, mosi SPI clock / data out
//   rx         received byte
//   done       last cycle of the byte
module jstk_spi_reader_spi_byte_shifter #(
  parameter int unsigned SCLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx,
  output logic       done
);

  localparam int unsigned DivW = $clog2(SCLK_DIV);

  logic [DivW-1:0] half_q;
  logic            high_q;
  logic [2:0]      bit_q;
  logic            busy_q;
  logic            sclk_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            half_end;

  assign half_end = (half_q == DivW'(SCLK_DIV - 1));
  assign done     = busy_q & high_q & half_end & (bit_q == 3'd7);
  assign sclk     = sclk_q;
  assign mosi     = busy_q & tx_q[7];
  assign rx       = rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= '0;
      high_q <= 1'b0;
      bit_q  <= 3'd0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        tx_q   <= tx;
        half_q <= '0;
        high_q <= 1'b0;
        bit_q  <= 3'd0;
      end
    end else if (!half_end) begin
      half_q <= half_q + 1'b1;
    end else begin
      half_q <= '0;
      if (!high_q) begin
        high_q <= 1'b1;
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], miso};
      end else begin
        // Falling edge: present the next bit for the following low half.
        high_q <= 1'b0;
        sclk_q <= 1'b0;
        tx_q   <= {tx_q[6:0], 1'b0};
        bit_q  <= bit_q + 3'd1;
        if (bit_q == 3'd7) busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jstk_spi_reader.sv
// Pmod JSTK poller. Every POLL_CYC idle cycles runs a 5-byte SPI mode-0
// transaction (ss setup, bytes separated by gaps) and then updates X, Y and the
// buttons together with a one-cycle data_valid pulse.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   miso           joystick serial data
//   sclk/mosi/ss   SPI master outputs (sclk idle low, ss active low)
//   led            {LD2,LD1}, latched at the start of each transaction
//   Xdata, Ydata   10-bit samples (reset to centre 512)
//   buttons        {btn2,btn1,stick_btn}
//   data_valid     high during the cycle the outputs take a new sample
module jstk_spi_reader
  import jstk_spi_reader_pkg::*;
#(
  parameter int unsigned SCLK_DIV     = 50,
  parameter int unsigned SS_SETUP_CYC = 1500,
  parameter int unsigned BYTE_GAP_CYC = 1000,
  parameter int unsigned POLL_CYC     = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  input  logic [1:0] led,
  output logic [9:0] Xdata,
  output logic [9:0] Ydata,
  output logic [2:0] buttons,
  output logic       data_valid
);

  localparam int unsigned CntMax0 = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int unsigned CntMax  = (POLL_CYC > CntMax0) ? POLL_CYC : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            ss_q, ss_d;
  logic [1:0]      led_q, led_d;
  logic [7:0]      x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]      x_hi_q, x_hi_d, y_hi_q, y_hi_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            dv_q, dv_d;
  logic            start;
  logic            byte_done;
  logic [7:0]      rx;

  jstk_spi_reader_spi_byte_shifter #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .tx    (tx_byte(idx_q, led_q)),
    .miso  (miso),
    .sclk  (sclk),
    .mosi  (mosi),
    .rx    (rx),
    .done  (byte_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ss_d    = ss_q;
    led_d   = led_q;
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    dv_d    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cnt_q == CntW'(POLL_CYC - 1)) begin
          cnt_d   = '0;
          ss_d    = 1'b0;
          led_d   = led;
          state_d = StSetup;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SS_SETUP_CYC - 1)) begin
          cnt_d   = '0;
          start   = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (byte_done) begin
          idx_d = idx_q + 3'd1;
          unique case (idx_q)
            3'd0:    x_lo_d = rx;
            3'd1:    x_hi_d = rx[1:0];
            3'd2:    y_lo_d = rx;
            3'd3:    y_hi_d = rx[1:0];
            default: begin
              // Final byte: commit the whole sample at once so X, Y and buttons never mix.
              x_d   = {x_hi_q, x_lo_q};
              y_d   = {y_hi_q, y_lo_q};
              btn_d = rx[2:0];
              dv_d  = 1'b1;
            end
          endcase
          state_d = (idx_q == 3'(NumBytes - 1)) ? StDone : StGap;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(BYTE_GAP_CYC - 1)) begin
          cnt_d   = '0;
          start   = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        ss_d    = 1'b1;
        idx_d   = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      ss_q    <= 1'b1;
      led_q   <= 2'b00;
      x_lo_q  <= 8'h00;
      x_hi_q  <= 2'b00;
      y_lo_q  <= 8'h00;
      y_hi_q  <= 2'b00;
      x_q     <= ResetCentre;
      y_q     <= ResetCentre;
      btn_q   <= 3'b000;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ss_q    <= ss_d;
      led_q   <= led_d;
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      dv_q    <= dv_d;
    end
  end

  assign ss         = ss_q;
  assign Xdata      = x_q;
  assign Ydata      = y_q;
  assign buttons    = btn_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: a JSTK slave model serves randomised (and a few
// directed) samples, a scoreboard queue holds the expected sample per
// transaction, and a monitor compares on every data_valid and checks SPI timing.
module tb_jstk_spi_reader;

  localparam int unsigned SCLK_DIV     = 2;
  localparam int unsigned SS_SETUP_CYC = 4;
  localparam int unsigned BYTE_GAP_CYC = 4;
  localparam int unsigned POLL_CYC     = 200;
  localparam int unsigned TXN_LEN      = SS_SETUP_CYC + 5 * 16 * SCLK_DIV + 4 * BYTE_GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic [1:0] led;
  logic [9:0] Xdata;
  logic [9:0] Ydata;
  logic [2:0] buttons;
  logic       data_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jstk_spi_reader #(
    .SCLK_DIV     (SCLK_DIV),
    .SS_SETUP_CYC (SS_SETUP_CYC),
    .BYTE_GAP_CYC (BYTE_GAP_CYC),
    .POLL_CYC     (POLL_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miso       (miso),
    .sclk       (sclk),
    .mosi       (mosi),
    .ss         (ss),
    .led        (led),
    .Xdata      (Xdata),
    .Ydata      (Ydata),
    .buttons    (buttons),
    .data_valid (data_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- JSTK slave model ----------------
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [5:0] j1;
    logic [5:0] j3;
    logic [4:0] j4;
  } samp_t;

  samp_t       directed[$];
  logic [22:0] exp_q[$];
  samp_t       sl_s;
  logic [39:0] sl_word;
  logic [39:0] mosi_cap;
  int          rise_cnt;
  logic [1:0]  led_at_start;
  bit          aborting = 1'b1;
  int          txn_started = 0;
  int          dv_total = 0;

  task automatic add_dir(input int x, input int y, input int btn, input int j1, input int j3);
    samp_t s;
    s.x   = 10'(x);
    s.y   = 10'(y);
    s.btn = 3'(btn);
    s.j1  = 6'(j1);
    s.j3  = 6'(j3);
    s.j4  = 5'h1F;
    directed.push_back(s);
  endtask

  always @(negedge ss) begin
    if (directed.size() > 0) begin
      sl_s = directed.pop_front();
    end else begin
      sl_s.x   = 10'($urandom_range(0, 1023));
      sl_s.y   = 10'($urandom_range(0, 1023));
      sl_s.btn = 3'($urandom_range(0, 7));
      sl_s.j1  = 6'($urandom_range(0, 63));
      sl_s.j3  = 6'($urandom_range(0, 63));
      sl_s.j4  = 5'($urandom_range(0, 31));
    end
    sl_word = {sl_s.x[7:0], sl_s.j1, sl_s.x[9:8], sl_s.y[7:0], sl_s.j3, sl_s.y[9:8],
               sl_s.j4, sl_s.btn};
    miso         = sl_word[39];
    mosi_cap     = '0;
    rise_cnt     = 0;
    led_at_start = led;
    exp_q.push_back({sl_s.x, sl_s.y, sl_s.btn});
    txn_started++;
  end

  // Mode 0: slave shifts out on falling SCLK, captures on rising SCLK.
  always @(negedge sclk) begin
    if (!ss) begin
      sl_word = sl_word << 1;
      miso    = sl_word[39];
    end
  end

  always @(posedge sclk) begin
    if (!ss) begin
      mosi_cap = {mosi_cap[38:0], mosi};
      rise_cnt++;
    end
  end

  always @(posedge ss) begin
    if (!aborting) begin
      check("sclk_rises_per_txn", 32'(rise_cnt), 32'd40);
      check("mosi_stream", 32'(mosi_cap[39:32]), 32'({6'b100000, led_at_start}));
      check("mosi_fill_bytes", mosi_cap[31:0], 32'h0);
      check("one_dv_per_txn", 32'(dv_total), 32'(txn_started));
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  logic [9:0]  last_x, last_y;
  logic [2:0]  last_b;
  logic [22:0] e;
  bit          prev_ss;
  bit          hi_valid;
  int          hi_run, lo_run, ss_low_cyc, ss_hi_run;

  always @(negedge clk) begin
    if (rst) begin
      last_x   = 10'd512;
      last_y   = 10'd512;
      last_b   = 3'd0;
      prev_ss  = 1'b1;
      hi_valid = 1'b0;
      hi_run   = 0;
      lo_run   = 0;
      ss_low_cyc = 0;
      ss_hi_run  = 0;
    end else begin
      if (data_valid) begin
        dv_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_valid: got pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          check("Xdata", 32'(Xdata), 32'(e[22:13]));
          check("Ydata", 32'(Ydata), 32'(e[12:3]));
          check("buttons", 32'(buttons), 32'(e[2:0]));
        end
        last_x = Xdata;
        last_y = Ydata;
        last_b = buttons;
      end else begin
        check("hold_sample", 32'({Xdata, Ydata, buttons}), 32'({last_x, last_y, last_b}));
      end

      if (ss) begin
        if (!prev_ss) begin
          check("txn_len", 32'(ss_low_cyc), 32'(TXN_LEN));
          ss_hi_run = 0;
          hi_valid  = 1'b1;
        end
        ss_hi_run++;
      end else begin
        if (prev_ss) begin
          if (hi_valid) check("idle_len", 32'(ss_hi_run), 32'(POLL_CYC));
          ss_low_cyc = 0;
          hi_run     = 0;
          lo_run     = 0;
        end
        ss_low_cyc++;
        if (sclk) begin
          if (lo_run > 0) begin
            check("sclk_low_run",
                  32'((lo_run == SCLK_DIV) || (lo_run == SS_SETUP_CYC + SCLK_DIV) ||
                      (lo_run == BYTE_GAP_CYC + SCLK_DIV)), 32'd1);
          end
          lo_run = 0;
          hi_run++;
        end else begin
          if (hi_run > 0) check("sclk_high_run", 32'(hi_run), 32'(SCLK_DIV));
          hi_run = 0;
          lo_run++;
        end
      end
      prev_ss = ss;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic wait_txns(input int k, input bit rand_led);
    int target;
    int t;
    target = dv_total + k;
    t = 0;
    while (dv_total < target && t < k * int'(POLL_CYC + TXN_LEN + 50)) begin
      @(posedge clk);
      #1;
      t++;
      if (rand_led && $urandom_range(0, 149) == 0) led = 2'($urandom_range(0, 3));
    end
    check("txn_completed", 32'(dv_total >= target), 32'd1);
  endtask

  task automatic measure_first_fall();
    int n;
    n = 0;
    while (ss === 1'b1 && n < int'(POLL_CYC) + 50) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("first_ss_fall", 32'(n), 32'(POLL_CYC));
  endtask

  task automatic check_reset_values();
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_Xdata", 32'(Xdata), 32'd512);
    check("rst_Ydata", 32'(Ydata), 32'd512);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
  endtask

  initial begin
    int t;
    int dv_before;
    rst  = 1'b1;
    miso = 1'b0;
    led  = 2'b10;
    add_dir(0, 1000, 5, 0, 0);
    add_dir(500, 500, 0, 6'h3F, 6'h3F);
    add_dir(500, 12, 2, 6'h2A, 6'h15);
    add_dir(0, 1023, 7, 6'h3F, 6'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst      = 1'b0;
    aborting = 1'b0;
    measure_first_fall();

    wait_txns(4, 1'b0);
    wait_txns(3, 1'b1);

    // Abort a transaction in the middle of byte 2.
    t = 0;
    while (ss !== 1'b0 && t < int'(POLL_CYC) + 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("ss_fall_before_abort", 32'(ss), 32'd0);
    repeat (SS_SETUP_CYC + 32 * SCLK_DIV + 2 * BYTE_GAP_CYC + $urandom_range(2, 28))
      @(posedge clk);
    #3;
    aborting = 1'b1;
    rst      = 1'b1;
    #1;
    check_reset_values();
    exp_q.delete();
    dv_before   = dv_total;
    txn_started = dv_total;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    aborting = 1'b0;
    measure_first_fall();
    check("no_dv_after_abort", 32'(dv_total), 32'(dv_before));

    wait_txns(3, 1'b1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
